// File: rtl/bus_master_arb.sv
// Four-master round-robin bus arbiter: grants change one clk edge after the owner drops req_n.
// No preemption; s_* are a combinational mux of the owner's signals.
module bus_master_arb #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_n,
  input  logic              m1_req_n,
  input  logic              m2_req_n,
  input  logic              m3_req_n,
  output logic              m0_grnt_n,
  output logic              m1_grnt_n,
  output logic              m2_grnt_n,
  output logic              m3_grnt_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [ADDR_W-1:0] m2_addr,
  input  logic [ADDR_W-1:0] m3_addr,
  input  logic              m0_as_n,
  input  logic              m1_as_n,
  input  logic              m2_as_n,
  input  logic              m3_as_n,
  input  logic              m0_rw,
  input  logic              m1_rw,
  input  logic              m2_rw,
  input  logic              m3_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  input  logic [DATA_W-1:0] m1_wr_data,
  input  logic [DATA_W-1:0] m2_wr_data,
  input  logic [DATA_W-1:0] m3_wr_data,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_as_n,
  output logic              s_rw,
  output logic [DATA_W-1:0] s_wr_data
);

  logic [1:0] owner;
  logic [1:0] owner_nxt;
  logic [3:0] req_n;
  logic [1:0] cand;
  logic       found;

  assign req_n = {m3_req_n, m2_req_n, m1_req_n, m0_req_n};

  // Search starts just past the owner, so the releasing master ranks last.
  always_comb begin
    owner_nxt = owner;
    cand      = owner;
    found     = 1'b0;
    if (req_n[owner]) begin
      for (int i = 1; i < 4; i++) begin
        cand = owner + 2'(i);
        if (!found && !req_n[cand]) begin
          owner_nxt = cand;
          found     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) owner <= 2'd0;
    else       owner <= owner_nxt;
  end

  assign m0_grnt_n = (owner != 2'd0);
  assign m1_grnt_n = (owner != 2'd1);
  assign m2_grnt_n = (owner != 2'd2);
  assign m3_grnt_n = (owner != 2'd3);

  // Only the owner's lane is selected, so non-owner X values never reach the bus.
  always_comb begin
    s_addr    = m0_addr;
    s_rw      = m0_rw;
    s_wr_data = m0_wr_data;
    s_as_n    = m0_as_n | m0_req_n;
    case (owner)
      2'd1: begin
        s_addr    = m1_addr;
        s_rw      = m1_rw;
        s_wr_data = m1_wr_data;
        s_as_n    = m1_as_n | m1_req_n;
      end
      2'd2: begin
        s_addr    = m2_addr;
        s_rw      = m2_rw;
        s_wr_data = m2_wr_data;
        s_as_n    = m2_as_n | m2_req_n;
      end
      2'd3: begin
        s_addr    = m3_addr;
        s_rw      = m3_rw;
        s_wr_data = m3_wr_data;
        s_as_n    = m3_as_n | m3_req_n;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_master_arb.sv
// Directed bench for bus_master_arb: reset, hold, hand-off order, wrap, async reset, parking.
module tb_bus_master_arb;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic m0_req_n, m1_req_n, m2_req_n, m3_req_n;
  logic m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
  logic [ADDR_W-1:0] m0_addr, m1_addr, m2_addr, m3_addr;
  logic m0_as_n, m1_as_n, m2_as_n, m3_as_n;
  logic m0_rw, m1_rw, m2_rw, m3_rw;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;
  logic [ADDR_W-1:0] s_addr;
  logic s_as_n, s_rw;
  logic [DATA_W-1:0] s_wr_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_req_n(m0_req_n), .m1_req_n(m1_req_n), .m2_req_n(m2_req_n), .m3_req_n(m3_req_n),
    .m0_grnt_n(m0_grnt_n), .m1_grnt_n(m1_grnt_n), .m2_grnt_n(m2_grnt_n), .m3_grnt_n(m3_grnt_n),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m2_addr(m2_addr), .m3_addr(m3_addr),
    .m0_as_n(m0_as_n), .m1_as_n(m1_as_n), .m2_as_n(m2_as_n), .m3_as_n(m3_as_n),
    .m0_rw(m0_rw), .m1_rw(m1_rw), .m2_rw(m2_rw), .m3_rw(m3_rw),
    .m0_wr_data(m0_wr_data), .m1_wr_data(m1_wr_data), .m2_wr_data(m2_wr_data),
    .m3_wr_data(m3_wr_data),
    .s_addr(s_addr), .s_as_n(s_as_n), .s_rw(s_rw), .s_wr_data(s_wr_data)
  );

  // Active-low grants packed as {m3,m2,m1,m0}
  logic [3:0] grnt;
  assign grnt = {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {m0_req_n, m1_req_n, m2_req_n, m3_req_n} = 4'b1111;
    {m0_as_n, m1_as_n, m2_as_n, m3_as_n}     = 4'b0111;
    m0_addr = 30'h0000_0010; m1_addr = 30'h0000_1111;
    m2_addr = 30'h0100_0000; m3_addr = 30'h3000_0003;
    m0_rw = 1'b1; m1_rw = 1'b0; m2_rw = 1'b1; m3_rw = 1'b0;
    m0_wr_data = 32'hA0A0_0000; m1_wr_data = 32'hB1B1_1111;
    m2_wr_data = 32'hC2C2_2222; m3_wr_data = 32'hD3D3_3333;

    // Reset takes effect without a clock edge
    #3;
    chk("reset_grant", 64'(grnt), 64'(4'b1110));
    chk("reset_as_forced", 64'(s_as_n), 64'(1'b1));
    chk("reset_addr_m0", 64'(s_addr), 64'(30'h0000_0010));
    @(negedge clk);
    reset = 1'b0;

    // Idle parking on master 0
    for (int i = 0; i < 10; i++) begin
      step();
      chk("park0_grant", 64'(grnt), 64'(4'b1110));
      chk("park0_as", 64'(s_as_n), 64'(1'b1));
    end

    // Owner 0 holds while m2 waits
    m0_req_n = 1'b0;
    #1;
    chk("m0_as_passes", 64'(s_as_n), 64'(1'b0));
    chk("m0_rw", 64'(s_rw), 64'(1'b1));
    m2_req_n = 1'b0;
    step();
    chk("m0_hold_grant", 64'(grnt), 64'(4'b1110));
    step();
    chk("m0_hold_grant2", 64'(grnt), 64'(4'b1110));
    m0_req_n = 1'b1;
    #1;
    chk("no_same_cycle_grant", 64'(grnt), 64'(4'b1110));
    chk("released_as_forced", 64'(s_as_n), 64'(1'b1));
    step();
    chk("m2_granted", 64'(grnt), 64'(4'b1011));
    chk("m2_addr", 64'(s_addr), 64'(30'h0100_0000));
    chk("m2_wdata", 64'(s_wr_data), 64'(32'hC2C2_2222));
    chk("m2_rw", 64'(s_rw), 64'(1'b1));

    // Non-owner X must not reach the bus
    m0_addr = 'x; m0_as_n = 1'bx; m0_rw = 1'bx;
    m2_as_n = 1'b0;
    #1;
    chk("x_ignored_addr", 64'(s_addr), 64'(30'h0100_0000));
    chk("x_ignored_as", 64'(s_as_n), 64'(1'b0));
    m0_addr = 30'h0000_0010; m0_as_n = 1'b1; m0_rw = 1'b1;

    // Owner 2 releases with 0,1,3 requesting -> 3
    {m0_req_n, m1_req_n, m3_req_n} = 3'b000;
    m2_req_n = 1'b1;
    step();
    chk("to_m3", 64'(grnt), 64'(4'b0111));
    chk("m3_addr", 64'(s_addr), 64'(30'h3000_0003));
    m2_req_n = 1'b0;
    // Owner 3 releases with all others requesting -> wrap to 0
    m3_req_n = 1'b1;
    step();
    chk("wrap_to_m0", 64'(grnt), 64'(4'b1110));
    m3_req_n = 1'b0;

    // Owner 0 releases -> 1; then round-robin 2,3,0
    m0_req_n = 1'b1;
    step();
    chk("to_m1", 64'(grnt), 64'(4'b1101));
    m0_req_n = 1'b0;
    step();
    chk("m1_holds", 64'(grnt), 64'(4'b1101));
    m1_req_n = 1'b1;
    step();
    chk("rr_m2", 64'(grnt), 64'(4'b1011));
    m2_req_n = 1'b1;
    step();
    chk("rr_m3", 64'(grnt), 64'(4'b0111));
    m3_req_n = 1'b1;
    step();
    chk("rr_m0", 64'(grnt), 64'(4'b1110));

    // Move to owner 2 and pulse reset mid-transfer
    m2_req_n = 1'b0;
    m0_req_n = 1'b1;
    step();
    chk("pre_rst_m2", 64'(grnt), 64'(4'b1011));
    m2_as_n = 1'b0;
    #1;
    chk("pre_rst_as", 64'(s_as_n), 64'(1'b0));
    reset = 1'b1;
    #3;
    chk("async_rst_grant", 64'(grnt), 64'(4'b1110));
    reset = 1'b0;
    #1;
    chk("post_rst_hold", 64'(grnt), 64'(4'b1110));
    step();
    chk("post_rst_search", 64'(grnt), 64'(4'b1011));

    // Owner 2 releases, only m1 requesting -> 1 via wrap 3,0,1
    m1_req_n = 1'b0;
    m2_req_n = 1'b1;
    step();
    chk("to_m1_wrap", 64'(grnt), 64'(4'b1101));
    chk("m1_wdata", 64'(s_wr_data), 64'(32'hB1B1_1111));
    m1_as_n = 1'b0;
    #1;
    chk("m1_as_live", 64'(s_as_n), 64'(1'b0));

    // Owner 1 releases with no requests -> parks on 1, strobe suppressed
    m1_req_n = 1'b1;
    step();
    chk("park1_grant", 64'(grnt), 64'(4'b1101));
    chk("park1_as_lo", 64'(s_as_n), 64'(1'b1));
    m1_as_n = 1'b1;
    step();
    chk("park1_as_hi", 64'(s_as_n), 64'(1'b1));
    m1_as_n = 1'b0;
    step();
    chk("park1_as_lo2", 64'(s_as_n), 64'(1'b1));
    chk("park1_grant2", 64'(grnt), 64'(4'b1101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_master_arb.md
BUS_MASTER_ARB -- requirements
Module: bus_master_arb

Interface
REQ-001 Parameter ADDR_W, default 30, width of word address (matches shared address bus fed to bus_addr_dec).
REQ-002 Parameter DATA_W, default 32, width of word data.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 m0_req_n..m3_req_n  input  1 each  master N bus request, active-low.
REQ-006 m0_grnt_n..m3_grnt_n  output  1 each  master N bus grant, active-low.
REQ-007 m0_addr..m3_addr  input  ADDR_W each  master N word address.
REQ-008 m0_as_n..m3_as_n  input  1 each  master N address strobe, active-low.
REQ-009 m0_rw..m3_rw  input  1 each  master N access type, 1=read, 0=write.
REQ-010 m0_wr_data..m3_wr_data  input  DATA_W each  master N write data.
REQ-011 s_addr  output  ADDR_W  shared address bus to address decoder and slaves.
REQ-012 s_as_n  output  1  shared address strobe, active-low.
REQ-013 s_rw  output  1  shared access type.
REQ-014 s_wr_data  output  DATA_W  shared write data.

Function
REQ-015 Block SHALL hold a 2-bit owner register (0..3) identifying the bus-owning master.
REQ-016 Exactly one mN_grnt_n SHALL be 0 at all times: the one where N = owner; decode is combinational from owner only.
REQ-017 On each rising clk edge, if m[owner]_req_n = 0, owner SHALL be held (no preemption, unlimited tenure).
REQ-018 If m[owner]_req_n = 1, owner SHALL update to the first master with req_n = 0 searched in order owner+1, owner+2, owner+3 (mod 4).
REQ-019 Search SHALL wrap: owner 3 searches 0,1,2; owner 2 searches 3,0,1.
REQ-020 If no master requests, owner SHALL be held (bus parks on last owner; its grant stays asserted).
REQ-021 Grant latency: a waiting master SHALL see grant exactly one clk edge after the cycle in which the current owner's req_n is sampled 1; never the same cycle.
REQ-022 Simultaneous requests SHALL resolve solely by REQ-018 order; the releasing owner has lowest priority.
REQ-023 s_addr, s_rw, s_wr_data SHALL equal m[owner]_addr, _rw, _wr_data combinationally (no register stage).
REQ-024 s_as_n SHALL equal m[owner]_as_n when m[owner]_req_n = 0, and SHALL be forced to 1 when m[owner]_req_n = 1 (parked owner cannot issue strobes).
REQ-025 Requests from non-owners SHALL have no effect on s_* outputs.
REQ-026 Inputs from non-owners SHALL be ignored entirely, including X values.

Reset
REQ-027 reset = 1 SHALL immediately, without waiting for clk, set owner = 0: m0_grnt_n = 0, m1..m3_grnt_n = 1, s_* follow master 0 per REQ-023/024.
REQ-028 Reset asserted mid-tenure of any master SHALL abort it; first edge after reset release applies REQ-017/018 from owner 0.
REQ-029 No other state exists; all outputs are defined from reset onward.

Verification
REQ-030 Reset, all req_n = 1 -> m0_grnt_n = 0, others 1; s_as_n = 1 regardless of m0_as_n; owner stays 0 for 10 cycles.
REQ-031 owner 0 holding req, m2_req_n = 0 -> no grant change; m0_req_n -> 1 -> m2_grnt_n = 0 after next edge; s_addr = m2_addr (e.g. 30'h0100_0000 -> bus_addr_dec selects s1).
REQ-032 Owner 3, all four req_n = 0, m3 releases -> owner 0 next edge (wrap-around).
REQ-033 Owner 1, m0/m2/m3 requesting, m1 releases -> grant sequence 2, then 3, then 0 as each releases after one transfer (round-robin fairness).
REQ-034 Owner 2 mid-transfer (s_as_n = 0), reset pulsed 3 ns between edges -> m0_grnt_n = 0 and m2_grnt_n = 1 before next clk edge.
REQ-035 Owner 1 releases with no other requests -> owner stays 1, m1_grnt_n = 0, s_as_n = 1 while m1_as_n toggles.
